// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the bypassing register file.
//   DefDataW / DefAddrW : default register width and register address width
//   regAddrT            : register address sized from DefAddrW
//   dataWordT           : data word sized from DefDataW
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DefDataW = 16;
   localparam int DefAddrW = 4;

   typedef logic [DefAddrW-1:0] regAddrT;
   typedef logic [DefDataW-1:0] dataWordT;

endpackage

// File: rtl/regfile_rd_port.sv
// -----------------------------------------------------------------------------
// regfile_rd_port
// One read port of the register file: chooses between the zero register, the
// two write ports (forwarding) and the stored value, then optionally registers
// the result.
//   clk, rst             : clock and asynchronous active-high reset
//   rdEn                 : capture enable, only meaningful when RD_LAT = 1
//   rdAddr               : address being read
//   storedData           : current array contents at rdAddr
//   wrEn0/wrAddr0/wrData0: write port 0 as seen this cycle
//   wrEn1/wrAddr1/wrData1: write port 1 as seen this cycle
//   rdData               : read result
// -----------------------------------------------------------------------------
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DefDataW,
   parameter int ADDR_W  = DefAddrW,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1,
   parameter int RD_LAT  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdEn,
   input  logic [ADDR_W-1:0] rdAddr,
   input  logic [DATA_W-1:0] storedData,
   input  logic              wrEn0,
   input  logic [ADDR_W-1:0] wrAddr0,
   input  logic [DATA_W-1:0] wrData0,
   input  logic              wrEn1,
   input  logic [ADDR_W-1:0] wrAddr1,
   input  logic [DATA_W-1:0] wrData1,
   output logic [DATA_W-1:0] rdData
);

   logic [DATA_W-1:0] readValue;

   // Select the value this port should see. The zero register always wins and
   // is never forwarded. Port 1 is checked before port 0 because port 1 is the
   // one that lands in the array when both write the same register, so the
   // forwarded value always matches what the array will hold after the edge.
   always_comb begin
      readValue = storedData;
      if ((ZERO_R0 != 0) && (rdAddr == '0)) begin
         readValue = '0;
      end else if ((BYPASS != 0) && wrEn1 && (wrAddr1 == rdAddr)) begin
         readValue = wrData1;
      end else if ((BYPASS != 0) && wrEn0 && (wrAddr0 == rdAddr)) begin
         readValue = wrData0;
      end
   end

   generate
      if (RD_LAT == 1) begin : gRegistered
         logic [DATA_W-1:0] rdDataQ;

         // Registered read: capture only when enabled so the output holds its
         // last value even if the register behind it is rewritten meanwhile.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               rdDataQ <= '0;
            end else if (rdEn) begin
               rdDataQ <= readValue;
            end
         end

         assign rdData = rdDataQ;
      end else begin : gCombinational
         // Combinational read: clock, reset and enable play no part here.
         logic unusedInputs;
         assign unusedInputs = &{1'b0, clk, rst, rdEn};
         assign rdData       = readValue;
      end
   endgenerate

endmodule

// File: rtl/regfile_bypass.sv
// -----------------------------------------------------------------------------
// regfile_bypass
// Two-read / two-write register file with same-cycle forwarding, optional
// hardwired zero register and optional registered read ports.
//   clk, rst                  : clock and asynchronous active-high reset
//   rd_en                     : read capture enable (registered reads only)
//   rd_addr1 / rd_data1       : read port 1
//   rd_addr2 / rd_data2       : read port 2
//   wr_en0/wr_addr0/wr_data0  : write port 0 (lower priority)
//   wr_en1/wr_addr1/wr_data1  : write port 1 (wins on same-address conflict)
// -----------------------------------------------------------------------------
module regfile_bypass
   import regfile_pkg::*;
#(
   parameter int DATA_W  = DefDataW,
   parameter int ADDR_W  = DefAddrW,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1,
   parameter int RD_LAT  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   input  logic              wr_en0,
   input  logic [ADDR_W-1:0] wr_addr0,
   input  logic [DATA_W-1:0] wr_data0,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [NUM_REGS];
   logic              commit0;
   logic              commit1;
   logic              zeroHit0;
   logic              zeroHit1;

   // Decide which write ports actually reach the array. Writes aimed at the
   // hardwired zero register are dropped, and port 0 is dropped whenever
   // port 1 targets the same register in the same cycle.
   always_comb begin
      zeroHit0 = (ZERO_R0 != 0) && (wr_addr0 == '0);
      zeroHit1 = (ZERO_R0 != 0) && (wr_addr1 == '0);
      commit1  = wr_en1 && !zeroHit1;
      commit0  = wr_en0 && !zeroHit0 && !(wr_en1 && (wr_addr1 == wr_addr0));
   end

   // Storage array. Reset clears every register at once without waiting for
   // a clock edge; otherwise each surviving write port updates its register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (commit0) begin
            mem[wr_addr0] <= wr_data0;
         end
         if (commit1) begin
            mem[wr_addr1] <= wr_data1;
         end
      end
   end

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS),
      .RD_LAT (RD_LAT)
   ) uRdPort1 (
      .clk       (clk),
      .rst       (rst),
      .rdEn      (rd_en),
      .rdAddr    (rd_addr1),
      .storedData(mem[rd_addr1]),
      .wrEn0     (wr_en0),
      .wrAddr0   (wr_addr0),
      .wrData0   (wr_data0),
      .wrEn1     (wr_en1),
      .wrAddr1   (wr_addr1),
      .wrData1   (wr_data1),
      .rdData    (rd_data1)
   );

   regfile_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0),
      .BYPASS (BYPASS),
      .RD_LAT (RD_LAT)
   ) uRdPort2 (
      .clk       (clk),
      .rst       (rst),
      .rdEn      (rd_en),
      .rdAddr    (rd_addr2),
      .storedData(mem[rd_addr2]),
      .wrEn0     (wr_en0),
      .wrAddr0   (wr_addr0),
      .wrData0   (wr_data0),
      .wrEn1     (wr_en1),
      .wrAddr1   (wr_addr1),
      .wrData1   (wr_data1),
      .rdData    (rd_data2)
   );

endmodule

// File: tb/tb_regfile_bypass.sv
// -----------------------------------------------------------------------------
// tb_regfile_bypass
// Drives three configurations of regfile_bypass from one shared stimulus:
//   dutA : ZERO_R0=0, BYPASS=1, RD_LAT=0
//   dutB : ZERO_R0=1, BYPASS=0, RD_LAT=0
//   dutC : ZERO_R0=1, BYPASS=1, RD_LAT=1
// Each configuration has its own array model. Outputs are compared every
// cycle at the falling edge, with directed literal checks layered on top.
// -----------------------------------------------------------------------------
module tb_regfile_bypass;
   import regfile_pkg::*;

   localparam int NR = 16;

   logic     clk = 1'b0;
   logic     rst;
   logic     rdEn;
   regAddrT  rdAddr1, rdAddr2;
   logic     wrEn0, wrEn1;
   regAddrT  wrAddr0, wrAddr1;
   dataWordT wrData0, wrData1;
   dataWordT aData1, aData2, bData1, bData2, cData1, cData2;

   dataWordT memA [NR];
   dataWordT memB [NR];
   dataWordT memC [NR];
   dataWordT cOut1, cOut2;

   int  assertCount = 0;
   int  failCount   = 0;
   logic checkEn    = 1'b0;

   always #5 clk = ~clk;

   regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(0), .BYPASS(1), .RD_LAT(0)) dutA (
      .clk(clk), .rst(rst), .rd_en(rdEn),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(aData1), .rd_data2(aData2),
      .wr_en0(wrEn0), .wr_addr0(wrAddr0), .wr_data0(wrData0),
      .wr_en1(wrEn1), .wr_addr1(wrAddr1), .wr_data1(wrData1)
   );

   regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(0), .RD_LAT(0)) dutB (
      .clk(clk), .rst(rst), .rd_en(rdEn),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(bData1), .rd_data2(bData2),
      .wr_en0(wrEn0), .wr_addr0(wrAddr0), .wr_data0(wrData0),
      .wr_en1(wrEn1), .wr_addr1(wrAddr1), .wr_data1(wrData1)
   );

   regfile_bypass #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1), .BYPASS(1), .RD_LAT(1)) dutC (
      .clk(clk), .rst(rst), .rd_en(rdEn),
      .rd_addr1(rdAddr1), .rd_addr2(rdAddr2), .rd_data1(cData1), .rd_data2(cData2),
      .wr_en0(wrEn0), .wr_addr0(wrAddr0), .wr_data0(wrData0),
      .wr_en1(wrEn1), .wr_addr1(wrAddr1), .wr_data1(wrData1)
   );

   // What register a will contain after the coming edge, given the write
   // inputs currently applied: the zero register never changes, port 1 beats
   // port 0, and an untouched register keeps its value.
   function automatic dataWordT postWrite(input dataWordT cur, input bit zero, input regAddrT a);
      if (zero && a == 4'd0)               return 16'h0000;
      if (wrEn1 && wrAddr1 == a)           return wrData1;
      if (wrEn0 && wrAddr0 == a)           return wrData0;
      return cur;
   endfunction

   task automatic checkValue(input string name, input dataWordT act, input dataWordT exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reset empties every model array and the registered outputs immediately.
   always @(posedge rst) begin
      for (int i = 0; i < NR; i++) begin
         memA[i] = '0;
         memB[i] = '0;
         memC[i] = '0;
      end
      cOut1 = '0;
      cOut2 = '0;
   end

   // Model update at each rising edge: every register moves to its post-write
   // value, then the registered configuration samples the updated array.
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NR; i++) begin
            memA[i] = postWrite(memA[i], 1'b0, regAddrT'(i));
            memB[i] = postWrite(memB[i], 1'b1, regAddrT'(i));
            memC[i] = postWrite(memC[i], 1'b1, regAddrT'(i));
         end
         if (rdEn) begin
            cOut1 = memC[rdAddr1];
            cOut2 = memC[rdAddr2];
         end
      end
   end

   // Compare all six outputs against the model. Forwarding makes dutA show
   // the post-write value in the same cycle; dutB shows the pre-write array.
   task automatic checkOutput();
      checkValue("A.rd1", aData1, postWrite(memA[rdAddr1], 1'b0, rdAddr1));
      checkValue("A.rd2", aData2, postWrite(memA[rdAddr2], 1'b0, rdAddr2));
      checkValue("B.rd1", bData1, memB[rdAddr1]);
      checkValue("B.rd2", bData2, memB[rdAddr2]);
      checkValue("C.rd1", cData1, cOut1);
      checkValue("C.rd2", cData2, cOut2);
   endtask

   // Compare process: outputs are stable mid-cycle, inputs change after posedge.
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         checkOutput();
      end
   end

   task automatic applyStimulus(input logic en, input regAddrT a1, input regAddrT a2,
                                input logic we0, input regAddrT wa0, input dataWordT wd0,
                                input logic we1, input regAddrT wa1, input dataWordT wd1);
      rdEn    = en;
      rdAddr1 = a1;
      rdAddr2 = a2;
      wrEn0   = we0;
      wrAddr0 = wa0;
      wrData0 = wd0;
      wrEn1   = we1;
      wrAddr1 = wa1;
      wrData1 = wd1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic midCycle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      #2;
      checkValue("reset.A.rd1", aData1, 16'h0000);
      checkValue("reset.C.rd1", cData1, 16'h0000);
      checkValue("reset.C.rd2", cData2, 16'h0000);
      @(negedge clk);
      rst     = 1'b0;
      checkEn = 1'b1;
      tick();

      // Two ports writing different registers in the same cycle.
      applyStimulus(1'b1, 4'd3, 4'd7, 1'b1, 4'd3, 16'h1234, 1'b1, 4'd7, 16'hABCD);
      tick();
      applyStimulus(1'b1, 4'd3, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("basic.A.rd1", aData1, 16'h1234);
      checkValue("basic.A.rd2", aData2, 16'hABCD);
      checkValue("basic.B.rd2", bData2, 16'hABCD);
      checkValue("basic.C.rd1", cData1, 16'h1234);

      // Same-cycle forwarding versus stored value.
      tick();
      applyStimulus(1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 16'h0001, 1'b0, 4'd0, 16'h0);
      tick();
      applyStimulus(1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 16'h5555, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("bypass.A.rd1", aData1, 16'h5555);
      checkValue("bypass.B.rd1", bData1, 16'h0001);

      // Both ports hit r4: port 1 must win, also on the forwarded read.
      tick();
      applyStimulus(1'b1, 4'd4, 4'd4, 1'b1, 4'd4, 16'h1111, 1'b1, 4'd4, 16'h2222);
      midCycle();
      checkValue("conflict.A.fwd", aData1, 16'h2222);
      tick();
      applyStimulus(1'b1, 4'd4, 4'd4, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("conflict.A.rd1", aData1, 16'h2222);
      checkValue("conflict.B.rd1", bData1, 16'h2222);
      checkValue("conflict.C.rd1", cData1, 16'h2222);

      // Writes to r0 on both ports.
      tick();
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b1, 4'd0, 16'hFFFF);
      midCycle();
      checkValue("zero.B.rd1.same", bData1, 16'h0000);
      checkValue("zero.B.rd2.same", bData2, 16'h0000);
      checkValue("zero.A.rd1.same", aData1, 16'hFFFF);
      tick();
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("zero.B.rd1.after", bData1, 16'h0000);
      checkValue("zero.C.rd1.after", cData1, 16'h0000);
      checkValue("zero.C.rd2.after", cData2, 16'h0000);
      checkValue("zero.A.rd2.after", aData2, 16'hFFFF);

      // Registered read with enable hold.
      tick();
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b1, 4'd2, 16'h00AA, 1'b0, 4'd0, 16'h0);
      tick();
      applyStimulus(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      applyStimulus(1'b0, 4'd2, 4'd2, 1'b1, 4'd2, 16'h00BB, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("rdlat.capture", cData1, 16'h00AA);
      tick();
      applyStimulus(1'b0, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("rdlat.hold1", cData1, 16'h00AA);
      checkValue("rdlat.A.new", aData1, 16'h00BB);
      tick();
      midCycle();
      checkValue("rdlat.hold2", cData1, 16'h00AA);
      tick();
      applyStimulus(1'b1, 4'd2, 4'd2, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      midCycle();
      checkValue("rdlat.update", cData1, 16'h00BB);

      // Asynchronous reset pulse in the middle of a cycle.
      tick();
      applyStimulus(1'b1, 4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0);
      tick();
      applyStimulus(1'b1, 4'd5, 4'd5, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      midCycle();
      checkValue("rstmid.A.before", aData1, 16'hBEEF);
      checkValue("rstmid.C.before", cData1, 16'hBEEF);
      #1;
      rst = 1'b1;
      #1;
      checkValue("rstmid.A.during", aData1, 16'h0000);
      checkValue("rstmid.B.during", bData1, 16'h0000);
      checkValue("rstmid.C1.during", cData1, 16'h0000);
      checkValue("rstmid.C2.during", cData2, 16'h0000);
      #1;
      rst = 1'b0;

      // Randomised traffic, biased towards address collisions.
      for (int n = 0; n < 400; n++) begin
         regAddrT wa0, wa1, ra1, ra2;
         tick();
         wa0 = regAddrT'($urandom_range(0, NR - 1));
         wa1 = ($urandom_range(0, 3) == 0) ? wa0 : regAddrT'($urandom_range(0, NR - 1));
         ra1 = ($urandom_range(0, 2) == 0) ? wa1 : regAddrT'($urandom_range(0, NR - 1));
         ra2 = ($urandom_range(0, 2) == 0) ? wa0 : regAddrT'($urandom_range(0, NR - 1));
         applyStimulus(1'($urandom_range(0, 1)), ra1, ra2,
                       1'($urandom_range(0, 1)), wa0, dataWordT'($urandom),
                       1'($urandom_range(0, 1)), wa1, dataWordT'($urandom));
      end

      tick();
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
      tick();
      midCycle();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
